bcd_sub_serial: RTL and testbench
=================================

BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request pulse; it is sampled only in IDLE.
REQ-005 SHALL have port minuend, input, DIGITS x 4 bits: packed BCD digits, with index 0 as the least significant digit.
REQ-006 SHALL have port subtrahend, input, DIGITS x 4 bits: packed BCD digits, with the same ordering as minuend.
REQ-007 SHALL have port result, output, DIGITS x 4 bits: BCD difference, held stable between operations.
REQ-008 SHALL have port underflow, output, 1 bit: high when subtrahend > minuend; valid together with result.
REQ-009 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking result and underflow as valid.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after DIGITS cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL, at the IDLE edge where start=1, latch both operands into internal shift registers, clear the borrow, and clear the digit index.
- result and underflow keep their previous values until the final RUN edge overwrites them.
REQ-013 SHALL, on each RUN edge, process one digit pair LSD first.
- Compute t = a - b - borrow_in.
- If t < 0: digit = t + 10 and borrow_out = 1.
- Otherwise: digit = t and borrow_out = 0.
REQ-014 SHALL shift each computed digit into result MSD-side, so that after DIGITS RUN edges result[i] holds the difference of digit i.
REQ-015 SHALL, at the final RUN edge, set underflow to the final borrow_out and assert done for exactly the following cycle.
REQ-016 SHALL make latency fixed: start sampled at edge E0 gives done high from edge E0+DIGITS to edge E0+DIGITS+1.
REQ-017 SHALL ignore start while busy=1 or done=1, with no queuing.
REQ-018 SHALL treat any latched operand nibble greater than 9 as 9, with the clamp applied at the latch edge.
REQ-019 SHALL hold busy=1 exactly during RUN and done=1 exactly during DONE; busy and done are never high together.
REQ-020 SHALL, when the operands are equal, produce a result of all zeros with underflow=0.

Reset
REQ-021 SHALL, while rst_n=0 (asynchronously), force state to IDLE and force result, underflow, busy, done, the borrow, the index and the shift registers all to 0.
REQ-022 SHALL, on reset asserted mid-RUN, abandon the operation without producing a done pulse; a new start is accepted on the first edge after rst_n returns high.

Configuration
REQ-023 SHALL support macro BCD_SUB_CLAMP_EN, selected at compile time.
- Defined: when the final borrow is 1, result is forced to all zeros at the final RUN edge (score/lives floor); underflow is still reported as 1.
- Undefined: result is the ten's-complement wrap (for example 0005-0010 gives 9995) and underflow is 1.

Structure
REQ-024 SHALL place in shared package bcd_pkg:
- typedef bcd_digit_t (4-bit logic);
- constant BCD_MAX_DIGIT = 9;
- the state enum for IDLE/RUN/DONE.
REQ-025 SHALL implement the per-digit subtract (a, b, bin -> d, bout) as combinational sub-module bcd_sub_digit, instantiated once and reused serially.

Verification (DIGITS=4)
REQ-026 SHALL cover: minuend 1234, subtrahend 0567, start pulse -> done after 4 edges, result 0667, underflow 0, busy high for 4 cycles.
REQ-027 SHALL cover: minuend 0100, subtrahend 0001 -> result 0099, underflow 0 (borrow ripples across two digits).
REQ-028 SHALL cover: minuend 0005, subtrahend 0010 -> underflow 1, with result 9995 without BCD_SUB_CLAMP_EN and 0000 with it.
REQ-029 SHALL cover: start held high continuously with operands changed while in RUN -> exactly one done per IDLE entry, and each result matches the operands latched at the accepted start.
REQ-030 SHALL cover: rst_n pulsed low two edges after start -> no done pulse, all outputs 0; then 9999-9999 -> result 0000, underflow 0.
REQ-031 SHALL cover: minuend digit nibble 0xC -> treated as 9 (for example minuend 000C, subtrahend 0001 gives result 0008).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the serial subtractor.
// Holds the digit type, the largest legal digit and the FSM state enum.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_sub_digit.sv
// Single-digit BCD subtract with borrow in and borrow out.
// Inputs are assumed already clamped to 0..9.
import bcd_pkg::*;

module bcd_sub_digit (
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  logic [4:0] t;

  // Five-bit difference; bit 4 set means the digit went negative.
  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    bout = t[4];
    d    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor, one digit per clock, LSD first.
// Define BCD_SUB_CLAMP_EN to floor a negative result at all zeros.
import bcd_pkg::*;

module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIGITS*4-1:0] minuend,
  input  logic [DIGITS*4-1:0] subtrahend,
  output logic [DIGITS*4-1:0] result,
  output logic                underflow,
  output logic                busy,
  output logic                done
);

  localparam int W = DIGITS * 4;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  state_t     state;
  logic [W-1:0] a_sr;
  logic [W-1:0] b_sr;
  logic [W-1:0] acc;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] acc_next;
  logic         borrow;
  logic [3:0]   idx;
  bcd_digit_t   d;
  logic         bout;

  // Clamp every incoming nibble to a legal digit before latching.
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < DIGITS; i++) begin
      a_in[i*4 +: 4] = bcd_clamp(minuend[i*4 +: 4]);
      b_in[i*4 +: 4] = bcd_clamp(subtrahend[i*4 +: 4]);
    end
  end

  bcd_sub_digit u_digit (
    .a    (a_sr[3:0]),
    .b    (b_sr[3:0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign acc_next = W'({d, acc} >> 4);

  // Control FSM plus datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      acc       <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      result    <= '0;
      underflow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            acc    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 4;
          b_sr   <= b_sr >> 4;
          acc    <= acc_next;
          borrow <= bout;
          idx    <= idx + 4'd1;
          if (idx == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            underflow <= bout;
`ifdef BCD_SUB_CLAMP_EN
            result    <= bout ? '0 : acc_next;
`else
            result    <= acc_next;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Self-checking bench for bcd_sub_serial with DIGITS=4.
// Reference model works on plain integers, not on BCD digit logic.
module tb_bcd_sub_serial;

  localparam int D = 4;
  localparam int W = D * 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic [W-1:0] result;
  logic         underflow;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  bcd_sub_serial #(.DIGITS(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .result     (result),
    .underflow  (underflow),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int s;
    int p;
    int n;
    s = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(v[i*4 +: 4]);
      if (n > 9) n = 9;
      s = s + n * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W:0] model(input logic [W-1:0] m,
                                       input logic [W-1:0] s);
    int diff;
    int r;
    logic uf;
    diff = bcd2int(m) - bcd2int(s);
    uf = (diff < 0);
    r = uf ? diff + 10000 : diff;
`ifdef BCD_SUB_CLAMP_EN
    if (uf) r = 0;
`endif
    return {uf, int2bcd(r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] s);
    logic [W:0] e;
    logic [W-1:0] prev;
    int n;
    e = model(m, s);
    @(negedge clk);
    minuend = m;
    subtrahend = s;
    start = 1'b1;
    prev = result;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n <= D + 3) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("result_hold", 32'(result), 32'(prev));
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", n, D);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("result", 32'(result), 32'(e[W-1:0]));
    chk("underflow", 32'(underflow), 32'(e[W]));
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    logic [W:0] e;
    logic [W-1:0] cm;
    logic [W-1:0] cs;
    logic [W-1:0] nm;
    logic [W-1:0] ns;
    int n;
    int dones;

    rst_n = 1'b0;
    start = 1'b0;
    minuend = '0;
    subtrahend = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {29'd0, underflow, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0567);
    run_op(16'h0100, 16'h0001);
    run_op(16'h0005, 16'h0010);
    run_op(16'h000C, 16'h0001);
    run_op(16'h4321, 16'h4321);
    run_op(16'h0000, 16'h9999);

    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] rm;
      logic [W-1:0] rs;
      for (int i = 0; i < D; i++) begin
        rm[i*4 +: 4] = 4'($urandom_range(0, (k % 4 == 0) ? 15 : 9));
        rs[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      run_op(rm, rs);
    end

    cm = 16'h2468;
    cs = 16'h1357;
    @(negedge clk);
    minuend = cm;
    subtrahend = cs;
    start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!busy && n < 10);
      chk("hold_accept", 32'(busy), 32'd1);
      nm = int2bcd(int'($urandom_range(0, 9999)));
      ns = int2bcd(int'($urandom_range(0, 9999)));
      minuend = nm;
      subtrahend = ns;
      e = model(cm, cs);
      dones = 0;
      for (int j = 0; j < D + 1; j++) begin
        @(posedge clk);
        #1;
        chk("hold_excl", 32'(busy & done), 32'd0);
        if (done) begin
          dones++;
          chk("hold_result", 32'(result), 32'(e[W-1:0]));
          chk("hold_uf", 32'(underflow), 32'(e[W]));
        end
      end
      chk("hold_dones", dones, 1);
      cm = nm;
      cs = ns;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (D + 2) @(posedge clk);

    @(negedge clk);
    minuend = 16'h1234;
    subtrahend = 16'h0567;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", {29'd0, underflow, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < D + 2; j++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("midrst_nodone", dones, 0);
    chk("midrst_idle", 32'(busy), 32'd0);
    run_op(16'h9999, 16'h9999);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
